// File: rtl/btn_pkg.sv
`default_nettype none
// btn_pkg: default sizing constants and counter-width helper for btn_debounce_bank.
// Revision: 1.0
package btn_pkg;

  localparam int BTN_N_DEF          = 4;
  localparam int BTN_DEB_TICKS_DEF  = 4;
  localparam int BTN_HOLD_TICKS_DEF = 500;
  localparam int BTN_REP_TICKS_DEF  = 100;

  // Width needed to hold values 0..ticks.
  function automatic int btn_cnt_w(input int ticks);
    return (ticks < 1) ? 1 : $clog2(ticks + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce_ch.sv
`default_nettype none
// btn_debounce_ch: one button channel (2-FF sync, ce-gated debounce, press/release pulses).
// Optional auto-repeat of press while held when BTN_DEBOUNCE_REPEAT_EN is defined. Revision: 1.0
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEB_TICKS  = BTN_DEB_TICKS_DEF,
  parameter int CNT_W      = btn_cnt_w(BTN_DEB_TICKS_DEF)
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  parameter int HOLD_TICKS = BTN_HOLD_TICKS_DEF,
  parameter int REP_TICKS  = BTN_REP_TICKS_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic ce_i,
  input  logic btn_i,
  output logic level_o,
  output logic press_o,
  output logic release_o
);

  logic             meta_q, sync_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             rep_fire;

  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    if (ce_i) begin
      if (sync_q == level_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_W'(DEB_TICKS - 1)) begin
        level_d = sync_q;
        cnt_d   = '0;
        press_d = sync_q;
        rel_d   = ~sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    press_d = press_d | rep_fire;
  end

`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int HOLD_W = btn_cnt_w((HOLD_TICKS > REP_TICKS) ? HOLD_TICKS : REP_TICKS);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              rep_q, rep_d;

  // Counts ce ticks since acceptance; first period is HOLD_TICKS, then REP_TICKS.
  always_comb begin
    hold_d   = hold_q;
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (!level_q || rel_d) begin
      hold_d = '0;
      rep_d  = 1'b0;
    end else if (ce_i) begin
      if (hold_q == (rep_q ? HOLD_W'(REP_TICKS - 1) : HOLD_W'(HOLD_TICKS - 1))) begin
        hold_d   = '0;
        rep_d    = 1'b1;
        rep_fire = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
      rep_q  <= 1'b0;
    end else begin
      hold_q <= hold_d;
      rep_q  <= rep_d;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule
`default_nettype wire

// File: rtl/btn_debounce_bank.sv
`default_nettype none
// btn_debounce_bank: N independent debounced button channels sharing one ce tick.
// Define BTN_DEBOUNCE_REPEAT_EN for press auto-repeat while held. Revision: 1.0
module btn_debounce_bank
  import btn_pkg::*;
#(
  parameter int N          = BTN_N_DEF,
  parameter int DEB_TICKS  = BTN_DEB_TICKS_DEF
`ifdef BTN_DEBOUNCE_REPEAT_EN
  ,
  parameter int HOLD_TICKS = BTN_HOLD_TICKS_DEF,
  parameter int REP_TICKS  = BTN_REP_TICKS_DEF
`endif
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce_i,
  input  logic [N-1:0] btn_i,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o
);

  localparam int CNT_W = btn_cnt_w(DEB_TICKS);

  for (genvar i = 0; i < N; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_TICKS (DEB_TICKS),
      .CNT_W     (CNT_W)
`ifdef BTN_DEBOUNCE_REPEAT_EN
      ,
      .HOLD_TICKS(HOLD_TICKS),
      .REP_TICKS (REP_TICKS)
`endif
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ce_i     (ce_i),
      .btn_i    (btn_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce_bank.sv
`default_nettype none
// tb_btn_debounce_bank: directed stimulus, per-cycle model comparison plus literal checkpoints.
// Revision: 1.0
module tb_btn_debounce_bank;

  localparam int N   = 4;
  localparam int DEB = 4;
`ifdef BTN_DEBOUNCE_REPEAT_EN
  localparam int HOLD = 8;
  localparam int REP  = 3;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         ce;
  logic [N-1:0] btn;
  logic [N-1:0] level, press, rel;

  int checks   = 0;
  int failures = 0;

  btn_debounce_bank #(
    .N         (N),
    .DEB_TICKS (DEB)
`ifdef BTN_DEBOUNCE_REPEAT_EN
    ,
    .HOLD_TICKS(HOLD),
    .REP_TICKS (REP)
`endif
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ce_i     (ce),
    .btn_i    (btn),
    .level_o  (level),
    .press_o  (press),
    .release_o(rel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: s is btn seen two edges ago; a level flips after DEB consecutive differing ce samples.
  logic [N-1:0] m_d1, m_d2, m_level, m_press, m_rel, old_lvl;
  int           m_run [N];
  int           m_held[N];
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    m_valid = 1'b1;
    if (rst) begin
      m_d1 = '0; m_d2 = '0; m_level = '0; m_press = '0; m_rel = '0;
      for (int i = 0; i < N; i++) begin
        m_run[i]  = 0;
        m_held[i] = 0;
      end
    end else begin
      old_lvl = m_level;
      m_press = '0;
      m_rel   = '0;
      for (int i = 0; i < N; i++) begin
        if (ce) begin
          if (m_d2[i] == m_level[i]) m_run[i] = 0;
          else begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_level[i] = m_d2[i];
              m_run[i]   = 0;
              m_press[i] = m_d2[i];
              m_rel[i]   = ~m_d2[i];
            end
          end
        end
`ifdef BTN_DEBOUNCE_REPEAT_EN
        if (!old_lvl[i] || m_rel[i]) m_held[i] = 0;
        else if (ce) begin
          m_held[i]++;
          if (m_held[i] == HOLD || (m_held[i] > HOLD && (m_held[i] - HOLD) % REP == 0))
            m_press[i] = 1'b1;
        end
`endif
      end
      m_d2 = m_d1;
      m_d1 = btn;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_level",   32'(level), 32'(m_level));
      check("model_press",   32'(press), 32'(m_press));
      check("model_release", 32'(rel),   32'(m_rel));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  int cnt;

  initial begin
    rst = 1'b1; ce = 1'b1; btn = 4'hF;
    step(2);
    check("rst_level",   32'(level), 32'h0);
    check("rst_press",   32'(press), 32'h0);
    check("rst_release", 32'(rel),   32'h0);
    rst = 1'b0;
    step(5);
    check("held_rst_level_early", 32'(level), 32'h0);
    step(1);
    check("held_rst_level", 32'(level), 32'hF);
    check("held_rst_press", 32'(press), 32'hF);
    step(1);
    check("held_rst_press_once", 32'(press), 32'h0);

    btn = 4'h0;
    step(5);
    check("all_release_early", 32'(rel), 32'h0);
    step(1);
    check("all_release", 32'(rel),   32'hF);
    check("all_rel_lvl", 32'(level), 32'h0);
    step(1);
    check("all_release_once", 32'(rel), 32'h0);

    // clean press/release on channel 0
    btn = 4'h1;
    step(5);
    check("ch0_level_early", 32'(level), 32'h0);
    step(1);
    check("ch0_level", 32'(level), 32'h1);
    check("ch0_press", 32'(press), 32'h1);
    step(1);
    check("ch0_press_once", 32'(press), 32'h0);
    step(13);
    btn = 4'h0;
    step(6);
    check("ch0_release", 32'(rel),   32'h1);
    check("ch0_rel_lvl", 32'(level), 32'h0);
    step(1);
    check("ch0_release_once", 32'(rel), 32'h0);

    // bounce on channel 1
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      btn = (k % 2 == 0) ? 4'h2 : 4'h0;
      step(1);
      if (press[1] || rel[1]) cnt++;
    end
    btn = 4'h0;
    for (int k = 0; k < 10; k++) begin
      step(1);
      if (press[1] || rel[1]) cnt++;
    end
    check("bounce_pulses", 32'(cnt),      32'h0);
    check("bounce_level",  32'(level[1]), 32'h0);

    // ce one clk in ten
    btn = 4'h4;
    for (int k = 0; k < 50; k++) begin
      ce = (k % 10 == 0);
      step(1);
      if (k == 35) check("ce_gate_level_early", 32'(level[2]), 32'h0);
      if (k == 45) check("ce_gate_level",       32'(level[2]), 32'h1);
    end
    ce = 1'b1; btn = 4'h0;
    step(10);

    // simultaneous channels
    btn = 4'b1010;
    step(6);
    check("simul_press", 32'(press), 32'hA);
    check("simul_level", 32'(level), 32'hA);
    step(1);
    check("simul_press_once", 32'(press), 32'h0);

    // reset two ticks into a new change restarts every channel
    btn = 4'hF;
    step(4);
    rst = 1'b1;
    step(1);
    check("mid_rst_level", 32'(level), 32'h0);
    rst = 1'b0;
    step(5);
    check("mid_rst_restart_early", 32'(level), 32'h0);
    step(1);
    check("mid_rst_restart_level", 32'(level), 32'hF);
    check("mid_rst_restart_press", 32'(press), 32'hF);
    btn = 4'h0;
    step(10);

`ifdef BTN_DEBOUNCE_REPEAT_EN
    btn = 4'h8;
    step(6);
    check("rep_first_press", 32'(press[3]), 32'h1);
    cnt = 0;
    for (int k = 0; k < 18; k++) begin
      step(1);
      if (press[3]) cnt++;
    end
    check("rep_count", 32'(cnt), 32'd4);
    btn = 4'h0;
    step(8);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      step(1);
      if (press[3]) cnt++;
    end
    check("rep_stopped", 32'(cnt), 32'h0);
`endif

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
